// File: rtl/capture_sequencer.sv
// Capture sequencer: issues NUM_BLOCKS S2MM then NUM_BLOCKS MM2S datamover commands over a ring buffer.
// Define SEQ_TAG_CHECK_EN to treat a status whose tag nibble differs from the issued tag as an error.
module capture_sequencer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [22:0] BTT        = 23'h00_1000,
    parameter int          NUM_BLOCKS = 4,
    parameter int          RST_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  last_sts,
    output logic        m_axis_s2mm_cmdsts_aresetn,
    output logic        m_axis_mm2s_cmdsts_aresetn,
    output logic [71:0] S_AXIS_S2MM_CMD_tdata,
    output logic        S_AXIS_S2MM_CMD_tvalid,
    input  logic        S_AXIS_S2MM_CMD_tready,
    output logic [71:0] S_AXIS_MM2S_CMD_tdata,
    output logic        S_AXIS_MM2S_CMD_tvalid,
    input  logic        S_AXIS_MM2S_CMD_tready,
    input  logic [7:0]  M_AXIS_S2MM_STS_tdata,
    input  logic        M_AXIS_S2MM_STS_tkeep,
    input  logic        M_AXIS_S2MM_STS_tlast,
    input  logic        M_AXIS_S2MM_STS_tvalid,
    output logic        M_AXIS_S2MM_STS_tready,
    input  logic [7:0]  M_AXIS_MM2S_STS_tdata,
    input  logic        M_AXIS_MM2S_STS_tkeep,
    input  logic        M_AXIS_MM2S_STS_tlast,
    input  logic        M_AXIS_MM2S_STS_tvalid,
    output logic        M_AXIS_MM2S_STS_tready
);

    typedef enum logic [2:0] {IDLE, WR_CMD, WR_STS, RD_CMD, RD_STS, DONE, ERROR} state_t;

    localparam logic [15:0] LAST_BLK = 16'(NUM_BLOCKS - 1);
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);

    state_t      state, state_nxt;
    logic [31:0] addr;
    logic [15:0] blk;
    logic [3:0]  tag;
    logic        err_q;
    logic [7:0]  sts_q;
    logic [15:0] rst_cnt;
    logic        cmdsts_rstn;

    logic        sts_valid;
    logic [7:0]  sts_data;
    logic        tag_ok;
    logic        sts_good;
    logic        last_blk;

    logic unused_sts_sideband;
    assign unused_sts_sideband = ^{M_AXIS_S2MM_STS_tkeep, M_AXIS_S2MM_STS_tlast,
                                   M_AXIS_MM2S_STS_tkeep, M_AXIS_MM2S_STS_tlast};

    // Only the channel whose STS state is active is accepted; the other stays pending.
    assign sts_valid = (state == WR_STS) ? M_AXIS_S2MM_STS_tvalid :
                       (state == RD_STS) ? M_AXIS_MM2S_STS_tvalid : 1'b0;
    assign sts_data  = (state == RD_STS) ? M_AXIS_MM2S_STS_tdata : M_AXIS_S2MM_STS_tdata;

`ifdef SEQ_TAG_CHECK_EN
    assign tag_ok = (sts_data[3:0] == tag);
`else
    assign tag_ok = 1'b1;
`endif

    assign sts_good = sts_data[7] && (sts_data[6:4] == 3'b000) && tag_ok;
    assign last_blk = (blk == LAST_BLK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WR_CMD;
            WR_CMD:  if (S_AXIS_S2MM_CMD_tready) state_nxt = WR_STS;
            WR_STS:  if (sts_valid) state_nxt = !sts_good ? ERROR : (last_blk ? RD_CMD : WR_CMD);
            RD_CMD:  if (S_AXIS_MM2S_CMD_tready) state_nxt = RD_STS;
            RD_STS:  if (sts_valid) state_nxt = !sts_good ? ERROR : (last_blk ? DONE : RD_CMD);
            DONE:    state_nxt = IDLE;
            ERROR:   if (rst_cnt == RST_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr        <= BASE_ADDR;
            blk         <= '0;
            tag         <= '0;
            err_q       <= 1'b0;
            sts_q       <= '0;
            rst_cnt     <= '0;
            cmdsts_rstn <= 1'b0;
        end else begin
            cmdsts_rstn <= 1'b1;
            rst_cnt     <= (state == ERROR) ? rst_cnt + 16'd1 : 16'd0;
            if (state == IDLE && start) begin
                addr  <= BASE_ADDR;
                blk   <= '0;
                tag   <= '0;
                err_q <= 1'b0;
            end
            if (sts_valid) begin
                sts_q <= sts_data;
                if (!sts_good) begin
                    err_q <= 1'b1;
                end else if (last_blk) begin
                    addr <= BASE_ADDR;
                    blk  <= '0;
                    tag  <= '0;
                end else begin
                    // 32-bit add wraps naturally past the top of the address space.
                    addr <= addr + {9'b0, BTT};
                    blk  <= blk + 16'd1;
                    tag  <= tag + 4'd1;
                end
            end
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign err      = err_q;
    assign last_sts = sts_q;

    assign m_axis_s2mm_cmdsts_aresetn = cmdsts_rstn && (state != ERROR);
    assign m_axis_mm2s_cmdsts_aresetn = cmdsts_rstn && (state != ERROR);

    assign S_AXIS_S2MM_CMD_tdata  = {4'h0, tag, addr, 8'h00, 1'b1, BTT};
    assign S_AXIS_MM2S_CMD_tdata  = {4'h0, tag, addr, 8'h00, 1'b1, BTT};
    assign S_AXIS_S2MM_CMD_tvalid = (state == WR_CMD);
    assign S_AXIS_MM2S_CMD_tvalid = (state == RD_CMD);
    assign M_AXIS_S2MM_STS_tready = (state == WR_STS);
    assign M_AXIS_MM2S_STS_tready = (state == RD_STS);

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: ring buffer start address.
REQ-002 SHALL have parameter BTT, default 23'h00_1000: bytes per block command.
REQ-003 SHALL have parameter NUM_BLOCKS, default 4: blocks per pass, valid range 1..65535.
REQ-004 SHALL have parameter RST_CYCLES, default 8: datamover cmd/status reset width on error.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, named clk and reset, as listed in REQ-006 and REQ-007.
REQ-006 Port clk, input, 1 bit: clock for all logic.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port start, input, 1 bit: single-cycle pulse that begins a capture pass.
REQ-009 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-010 Port done, output, 1 bit: single-cycle pulse when a pass completes without error.
REQ-011 Port err, output, 1 bit: sticky error flag.
REQ-012 Port last_sts, output, 8 bits: most recent status byte accepted.
REQ-013 Ports m_axis_s2mm_cmdsts_aresetn and m_axis_mm2s_cmdsts_aresetn, output, 1 bit each: datamover cmd/status resets.
REQ-014 Ports S_AXIS_S2MM_CMD_tdata/tvalid/tready and S_AXIS_MM2S_CMD_tdata/tvalid/tready: widths 72/1/1; tready is an input; tdata and tvalid are outputs.
REQ-015 Ports M_AXIS_S2MM_STS_tdata/tkeep/tlast/tvalid/tready and M_AXIS_MM2S_STS_tdata/tkeep/tlast/tvalid/tready: widths 8/1/1/1/1; tready is an output; all others are inputs; tkeep and tlast are ignored.

Function
REQ-016 SHALL form each command as {4'h0, tag[3:0], addr[31:0], 8'h00, 1'b1, BTT[22:0]}.
REQ-017 SHALL implement FSM states IDLE, WR_CMD, WR_STS, RD_CMD, RD_STS, DONE, and ERROR.
REQ-018 In IDLE, a start pulse SHALL set addr to BASE_ADDR, blk to 0, tag to 0, and err to 0, then go to WR_CMD; start SHALL be ignored in all other states.
REQ-019 In WR_CMD, S2MM CMD tvalid SHALL be 1 and tdata SHALL be held stable; on tready the FSM SHALL go to WR_STS.
REQ-020 S2MM STS tready SHALL be 1 only in WR_STS; on tvalid, tdata SHALL be latched into last_sts.
REQ-021 In WR_STS, a good status is bit7=1 and bits6:4=0.
REQ-022 In WR_STS, good status with blk<NUM_BLOCKS-1 SHALL do addr+=BTT, blk+=1, tag+=1 (mod 16), then go to WR_CMD.
REQ-023 In WR_STS, good status with blk==NUM_BLOCKS-1 SHALL reset addr, blk, and tag to BASE_ADDR/0/0, then go to RD_CMD.
REQ-024 RD_CMD and RD_STS SHALL behave as REQ-019 to REQ-023 on the MM2S channels; the final good status SHALL go to DONE.
REQ-025 Any bad status SHALL set err=1 and go to ERROR.
REQ-026 Address arithmetic SHALL be 32-bit and wrap modulo 2^32 without error.
REQ-027 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-028 ERROR SHALL drive both cmdsts_aresetn outputs low for RST_CYCLES cycles, then go to IDLE; err SHALL stay high until the next accepted start.
REQ-029 Command tvalid SHALL be 0 in every state except its own CMD state.
REQ-030 Status tvalid arriving outside its STS state SHALL be left pending (tready=0).

Reset
REQ-031 While reset is high: state=IDLE, busy=0, done=0, err=0, last_sts=0, all CMD tvalid=0, all STS tready=0, both cmdsts_aresetn=0.
REQ-032 Both cmdsts_aresetn outputs SHALL go to 1 on the first clk edge after reset is released.
REQ-033 Reset asserted mid-pass SHALL abort immediately with no further commands issued.

Configuration
REQ-034 With SEQ_TAG_CHECK_EN defined, a status whose bits3:0 differ from the issued tag SHALL count as bad status (REQ-025).
REQ-035 Without SEQ_TAG_CHECK_EN, status bits3:0 SHALL be ignored.

Verification
REQ-036 Defaults; start; all tready=1; every status is 8'h80|tag -> 4 S2MM commands at addr 0x0, 0x1000, 0x2000, 0x3000 with tags 0..3, then 4 MM2S commands at the same addresses, then done=1 for one cycle and busy=0.
REQ-037 S2MM CMD tready held low for 10 cycles -> tvalid stays 1 and tdata stays constant; advance occurs on the cycle tready rises.
REQ-038 Second S2MM status = 8'hC1 (SLVERR) -> err=1; both cmdsts_aresetn low for exactly 8 cycles; then IDLE; no MM2S command issued.
REQ-039 Tag check defined; first status = 8'h85 -> ERROR. Tag check undefined; same stimulus -> pass continues.
REQ-040 BASE_ADDR=32'hFFFF_F000, NUM_BLOCKS=2 -> addresses 0xFFFF_F000 then 0x0000_0000, err=0.
REQ-041 Reset asserted while in RD_STS -> all outputs at REQ-031 values immediately; a new start after release runs a full pass.
